// File: rtl/irda_out.sv
// -----------------------------------------------------------------------------
// irda_out : serial frame transmitter for the IrDA link.
//   Accepts a nibble on a valid/ready handshake and sends one 6-bit frame:
//   start (high), 4 data bits LSB first, stop (low). The line idles low.
//   Each bit level lasts DIV clocks.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   din      in   [3:0] nibble to send, sampled on accept
//   din_vld  in   request to send din
//   din_rdy  out  high while idle (decoded from the state register)
//   Oout     out  registered serial line to the IR LED driver
//   tx_done  out  registered one-cycle pulse on the last clock of the stop bit
//
// Build option
//   IRDA_CARRIER_EN : when defined, high line levels are gated with a
//                     CAR_DIV-period square-wave carrier.
// -----------------------------------------------------------------------------
module irda_out #(
    parameter int unsigned DIV     = 100000,
    parameter int unsigned FRA     = 6,
    parameter int unsigned CAR_DIV = 1316
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       Oout,
    output logic       tx_done
);

    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DATA_BITS = FRA - 2;
    localparam logic [1:0]  LAST_BIT = 2'(DATA_BITS - 1);

    // Reject parameter sets the frame format cannot support
    generate
        if (DIV < 4 || DIV > 131071 || FRA != 6 || CAR_DIV < 2) begin : g_bad_params
            $error("irda_out: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] w_cnt0_nxt;
    logic [1:0]       r_cnt1;
    logic [1:0]       w_cnt1_nxt;
    logic [3:0]       r_shreg;
    logic [3:0]       w_shreg_nxt;
    logic             r_oout;
    logic             r_tx_done;
    logic             w_level;
    logic             w_line;
    logic             w_done;
    logic             w_wrap;

    assign w_wrap  = (r_cnt0 == CNT_W'(DIV - 1));
    assign din_rdy = (r_state == S_IDLE);
    assign Oout    = r_oout;
    assign tx_done = r_tx_done;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_shreg   <= '0;
            r_oout    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt0    <= w_cnt0_nxt;
            r_cnt1    <= w_cnt1_nxt;
            r_shreg   <= w_shreg_nxt;
            r_oout    <= w_line;
            r_tx_done <= w_done;
        end
    end

    // Next-state, counters and unregistered line level
    always_comb begin
        w_state_nxt = r_state;
        w_cnt0_nxt  = r_cnt0;
        w_cnt1_nxt  = r_cnt1;
        w_shreg_nxt = r_shreg;
        w_level     = 1'b0;
        w_done      = 1'b0;

        // Bit-period counter runs in every busy state
        if (r_state != S_IDLE) begin
            w_cnt0_nxt = w_wrap ? '0 : r_cnt0 + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (din_vld) begin
                    w_state_nxt = S_START;
                    w_shreg_nxt = din;
                    w_cnt0_nxt  = '0;
                    w_cnt1_nxt  = '0;
                end
            end
            S_START: begin
                w_level = 1'b1;
                if (w_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_level = r_shreg[0];
                if (w_wrap) begin
                    w_shreg_nxt = {1'b0, r_shreg[3:1]};
                    w_cnt1_nxt  = r_cnt1 + 2'd1;
                    if (r_cnt1 == LAST_BIT) begin
                        w_state_nxt = S_STOP;
                        w_cnt1_nxt  = '0;
                    end
                end
            end
            S_STOP: begin
                w_level = 1'b0;
                if (w_wrap) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef IRDA_CARRIER_EN
    localparam int unsigned CAR_W = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;

    logic [CAR_W-1:0] r_car_cnt;
    logic             w_carrier;
    logic             w_accept;

    assign w_accept  = (r_state == S_IDLE) && din_vld;
    assign w_carrier = (r_car_cnt < CAR_W'(CAR_DIV / 2));
    assign w_line    = w_level & w_carrier;

    // Carrier phase restarts on accept so each frame opens with the carrier high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car_cnt <= '0;
        end else if (w_accept) begin
            r_car_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_car_cnt <= (r_car_cnt == CAR_W'(CAR_DIV - 1)) ? '0 : r_car_cnt + CAR_W'(1);
        end
    end
`else
    assign w_line = w_level;
`endif

endmodule
